elevator_car_ctrl: RTL and testbench

Car-motion controller for the elevator: latches floor requests, moves the car one floor at a time, and at each served floor drives the door block through its `open`/`close_n` handshake. It is the initiator side of the door interface: it issues the one-cycle `open` pulse, waits for the door to report open (`close_n` low), then waits for it to report closed (`close_n` high) before deciding the next move. It sits between the request buttons and the door timer.

---
 rtl/elevator_car_ctrl_if.sv | 26 ++
 rtl/elevator_car_ctrl.sv | 134 +++++++++++++
 tb/tb_elevator_car_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_car_ctrl_if.sv
// Signal bundle between the car controller, the request buttons and the door block.
// Door handshake: controller pulses open for one cycle; door drops close_n while open and raises it once closed.
interface elevator_car_ctrl_if #(
    parameter int FLOORS = 4
);
    localparam int FW = $clog2(FLOORS);

    logic [FLOORS-1:0] req;
    logic              close_n;
    logic              open;
    logic [FW-1:0]     floor;
    logic              dir_up;
    logic              moving;
    logic [FLOORS-1:0] pending;
    logic [2:0]        state;

    modport master (
        input  req, close_n,
        output open, floor, dir_up, moving, pending, state
    );

    modport slave (
        output req, close_n,
        input  open, floor, dir_up, moving, pending, state
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Car-motion controller: latches calls, steps the car floor by floor, and runs the door handshake
// at every served floor. The state register is exported on bus.state for observation.
module elevator_car_ctrl #(
    parameter int FLOORS  = 4,
    parameter int TRAVEL  = 3,
    parameter int DOOR_TO = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    elevator_car_ctrl_if.master   bus
);
    localparam int FW = $clog2(FLOORS);
    localparam int TW = (TRAVEL  > 1) ? $clog2(TRAVEL)  : 1;
    localparam int DW = (DOOR_TO > 1) ? $clog2(DOOR_TO) : 1;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        MOVE       = 3'd1,
        OPEN_REQ   = 3'd2,
        WAIT_OPEN  = 3'd3,
        WAIT_CLOSE = 3'd4
    } state_t;

    state_t            state_q;
    logic [FW-1:0]     floor_q;
    logic              dir_q;
    logic [FLOORS-1:0] pending_q;
    logic [TW-1:0]     travel_cnt;
    logic [DW-1:0]     to_cnt;

    logic              any_above;
    logic              any_below;
    logic              door_busy;
    logic [FLOORS-1:0] set_mask;
    logic [FLOORS-1:0] pend_nxt;
    logic [FW-1:0]     step_floor;
    state_t            dec_state;
    logic              dec_dir;

    assign bus.open    = (state_q == OPEN_REQ);
    assign bus.moving  = (state_q == MOVE);
    assign bus.floor   = floor_q;
    assign bus.dir_up  = dir_q;
    assign bus.pending = pending_q;
    assign bus.state   = state_q;

    assign door_busy  = (state_q == OPEN_REQ) || (state_q == WAIT_OPEN) || (state_q == WAIT_CLOSE);
    assign step_floor = dir_q ? floor_q + FW'(1) : floor_q - FW'(1);

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(floor_q)) any_above = any_above | pending_q[i];
            if (i < int'(floor_q)) any_below = any_below | pending_q[i];
        end
    end

    // The door is already serving the current floor, so a press there is dropped; the clear wins.
    always_comb begin
        set_mask = bus.req;
        if (door_busy) set_mask[floor_q] = 1'b0;
        pend_nxt = pending_q | set_mask;
        if (state_q == OPEN_REQ) pend_nxt[floor_q] = 1'b0;
    end

    // Keep going the current way while there is work ahead, otherwise turn around.
    always_comb begin
        dec_state = IDLE;
        dec_dir   = dir_q;
        if (pending_q[floor_q]) begin
            dec_state = OPEN_REQ;
        end else if (dir_q && any_above) begin
            dec_state = MOVE;
            dec_dir   = 1'b1;
        end else if (any_below) begin
            dec_state = MOVE;
            dec_dir   = 1'b0;
        end else if (any_above) begin
            dec_state = MOVE;
            dec_dir   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            pending_q  <= '0;
            travel_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            pending_q <= pend_nxt;
            case (state_q)
                IDLE: begin
                    state_q    <= dec_state;
                    dir_q      <= dec_dir;
                    travel_cnt <= '0;
                end
                MOVE: begin
                    if (travel_cnt == TW'(TRAVEL - 1)) begin
                        travel_cnt <= '0;
                        floor_q    <= step_floor;
                        if (pending_q[step_floor]) state_q <= OPEN_REQ;
                    end else begin
                        travel_cnt <= travel_cnt + TW'(1);
                    end
                end
                OPEN_REQ: begin
                    state_q <= WAIT_OPEN;
                    to_cnt  <= '0;
                end
                WAIT_OPEN: begin
                    if (!bus.close_n) begin
                        state_q <= WAIT_CLOSE;
                    end else if (to_cnt == DW'(DOOR_TO - 1)) begin
                        state_q <= OPEN_REQ;
                    end else begin
                        to_cnt <= to_cnt + DW'(1);
                    end
                end
                WAIT_CLOSE: begin
                    if (bus.close_n) begin
                        state_q    <= dec_state;
                        dir_q      <= dec_dir;
                        travel_cnt <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl: single call, door timeout, collective up/down,
// pickup en route, same-floor press during door open, asynchronous reset mid-travel.
module tb_elevator_car_ctrl;
    localparam int S_IDLE = 0, S_MOVE = 1, S_OPEN_REQ = 2, S_WAIT_OPEN = 3, S_WAIT_CLOSE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    elevator_car_ctrl_if #(.FLOORS(4)) bus ();

    elevator_car_ctrl #(.FLOORS(4), .TRAVEL(3), .DOOR_TO(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Door block: close_n low for n cycles, then high for the closing edge.
    task automatic door_serve(input int n);
        bus.close_n = 1'b0;
        tick(n);
        bus.close_n = 1'b1;
        tick();
    endtask

    task automatic call(input logic [3:0] r);
        bus.req = r;
        tick();
        bus.req = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.req     = 4'b0000;
        bus.close_n = 1'b1;
        tick(2);
        check("rst_open",    bus.open,    0);
        check("rst_floor",   bus.floor,   0);
        check("rst_dir",     bus.dir_up,  1);
        check("rst_moving",  bus.moving,  0);
        check("rst_pending", bus.pending, 0);
        rst_n = 1'b1;
        tick();
        check("rst_state", bus.state, S_IDLE);

        // Single call to floor 2
        call(4'b0100);
        check("t1_pend_latch", bus.pending, 4'b0100);
        check("t1_idle_hold",  bus.moving,  0);
        tick();
        check("t1_move",       bus.moving,  1);
        check("t1_floor0",     bus.floor,   0);
        tick(3);
        check("t1_floor1",     bus.floor,   1);
        check("t1_still_move", bus.moving,  1);
        tick(3);
        check("t1_floor2",     bus.floor,   2);
        check("t1_open",       bus.open,    1);
        check("t1_stop",       bus.moving,  0);
        tick();
        check("t1_open_pulse", bus.open,    0);
        check("t1_pend_clr",   bus.pending, 0);
        check("t1_wait_open",  bus.state,   S_WAIT_OPEN);
        door_serve(4);
        check("t1_idle",       bus.state,   S_IDLE);
        check("t1_idle_mov",   bus.moving,  0);
        check("t1_idle_floor", bus.floor,   2);

        // Door timeout: first open ignored, retry 5 cycles later
        call(4'b0100);
        tick();
        check("to_open1",   bus.open,  1);
        tick(4);
        check("to_gap",     bus.open,  0);
        check("to_waiting", bus.state, S_WAIT_OPEN);
        tick();
        check("to_open2",   bus.open,  1);
        tick();
        door_serve(2);
        check("to_done",    bus.state, S_IDLE);

        // Collective: at floor 1 heading up with floors 3 and 0 pending
        do_reset();
        call(4'b0010);
        tick(4);
        check("col_at1",     bus.floor,   1);
        check("col_open1",   bus.open,    1);
        tick();
        call(4'b1001);
        check("col_pend",    bus.pending, 4'b1001);
        door_serve(2);
        check("col_up_mov",  bus.moving,  1);
        check("col_up_dir",  bus.dir_up,  1);
        tick(3);
        check("col_pass2",   bus.moving,  1);
        tick(3);
        check("col_at3",     bus.floor,   3);
        check("col_open3",   bus.open,    1);
        tick();
        check("col_pend0",   bus.pending, 4'b0001);
        door_serve(2);
        check("col_dn_dir",  bus.dir_up,  0);
        check("col_dn_mov",  bus.moving,  1);
        tick(9);
        check("col_at0",     bus.floor,   0);
        check("col_open0",   bus.open,    1);
        tick();
        door_serve(1);
        check("col_idle",    bus.state,   S_IDLE);
        check("col_pend_e",  bus.pending, 0);

        // Pickup en route: heading to 3, call at 2 raised while at floor 1
        call(4'b1000);
        tick();
        check("pk_dir",     bus.dir_up, 1);
        check("pk_move",    bus.moving, 1);
        tick(3);
        check("pk_at1",     bus.floor,  1);
        call(4'b0100);
        tick(2);
        check("pk_at2",     bus.floor,  2);
        check("pk_open2",   bus.open,   1);
        tick();
        door_serve(1);
        check("pk_resume",  bus.moving, 1);
        tick(3);
        check("pk_at3",     bus.floor,  3);
        check("pk_open3",   bus.open,   1);
        tick();

        // Same-floor press held while the door is open
        bus.close_n = 1'b0;
        bus.req     = 4'b1000;
        tick(3);
        check("sf_wclose",  bus.state,   S_WAIT_CLOSE);
        check("sf_pend",    bus.pending, 0);
        bus.close_n = 1'b1;
        bus.req     = 4'b0000;
        tick();
        check("sf_idle",    bus.state,   S_IDLE);
        tick(3);
        check("sf_no_open", bus.open,    0);
        check("sf_still",   bus.state,   S_IDLE);

        // Asynchronous reset mid-travel at floor 1
        call(4'b0001);
        tick();
        check("ar_dir",     bus.dir_up, 0);
        tick(7);
        check("ar_floor1",  bus.floor,  1);
        check("ar_moving",  bus.moving, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_open",    bus.open,    0);
        check("ar_floor",   bus.floor,   0);
        check("ar_dir_up",  bus.dir_up,  1);
        check("ar_mov0",    bus.moving,  0);
        check("ar_pend",    bus.pending, 0);
        #3 rst_n = 1'b1;
        tick();
        check("ar_state",   bus.state,   S_IDLE);
        check("ar_pend2",   bus.pending, 0);
        check("ar_floor2",  bus.floor,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
